fft8_bfly_scheduler: RTL and testbench
======================================

// Module: fft8_bfly_scheduler
// PURPOSE
//  Sequences the shared Butterfly_Unit through the 3 radix-2 DIT stages of the 8-point FFT.
//  Per stage: issues 4 butterflies (one per cycle) to a ping-pong complex buffer, supplying
//  read addresses, the read bank and a W8 twiddle index. Delays the matching write-back
//  addresses by the read+butterfly pipeline depth, then drains before the next stage.
//  Sits between the top-level FFT control (start/done) and the buffer/twiddle ROM/butterfly.
// PARAMETERS
//  RD_LAT    1  buffer read latency in cycles (>=0)
//  BFLY_LAT  2  Butterfly_Unit pipeline depth in cycles (>=0); PIPE = RD_LAT+BFLY_LAT, must be >=1
// PORTS
//  i_clk          in   1  clock, rising edge
//  i_rst          in   1  asynchronous active-high reset
//  i_start        in   1  start pulse; honoured only in IDLE
//  o_busy         out  1  high from first ISSUE cycle until last write-back cycle inclusive
//  o_done         out  1  one-cycle pulse the cycle after the final stage-2 write-back
//  o_rd_valid     out  1  butterfly issue this cycle
//  o_rd_bank      out  1  bank read = stage[0]
//  o_rd_addr0     out  3  upper butterfly input address
//  o_rd_addr1     out  3  lower butterfly input address
//  o_tw_idx       out  2  twiddle index k of W8^k (ROM lookup, k in 0..3)
//  o_stage        out  2  current stage 0..2 (0 in IDLE)
//  o_wr_en        out  1  write-back strobe for both outputs of one butterfly
//  o_wr_bank      out  1  bank written = ~bank read at issue
//  o_wr_addr0     out  3  address for o_data_0 of the butterfly
//  o_wr_addr1     out  3  address for o_data_1 of the butterfly
// BEHAVIOUR
//  Reset: FSM=IDLE, counters 0, all outputs 0, delay line cleared. Async assert, sync release.
//  FSM: IDLE -(i_start)-> ISSUE -(k==3)-> DRAIN -(last write, stage<2)-> ISSUE (stage+1)
//       DRAIN -(last write, stage==2)-> DONE -> IDLE. DONE lasts one cycle (o_done=1).
//  Addressing, stage s, butterfly k (0..3): span=1<<s, grp=k>>s, pos=k&(span-1);
//   addr0 = grp*2*span + pos; addr1 = addr0 + span; tw_idx = pos << (2-s).
//   s0: (0,1)(2,3)(4,5)(6,7) tw 0; s1: (0,2)(1,3)(4,6)(5,7) tw 0,2,0,2; s2: (k,k+4) tw k.
//  Input data is bit-reversed in bank 0 before start; the result is in bank 1 at o_done.
//  Write-back: {valid, bank, addr0, addr1} shift register of depth PIPE; o_wr_* = issue
//   fields delayed exactly PIPE cycles. No write occurs without a matching issue.
//  Drain: next stage issues the cycle after the previous stage's 4th write (no RAW overlap).
//  Cycle count (cycle n = after edge n, start sampled at edge 0): stage = 4+PIPE cycles;
//   o_done at cycle 3*(4+PIPE)+1; o_busy low in IDLE and DONE.
//  i_start while busy/DONE: ignored, no restart, no queuing.
//  o_rd_* outputs are 0 when o_rd_valid=0; o_wr_* are 0 when o_wr_en=0.
//  Reset mid-run: everything returns to IDLE immediately; pending writes are discarded.
// TESTING
//  Defaults (PIPE=3), start at edge 0 -> rd_valid cycles 1-4, 8-11, 15-18; wr_en 4-7, 11-14,
//   18-21; o_done only at cycle 22; o_busy high cycles 1-21.
//  Address/twiddle trace -> matches the stage table above, rd_bank 0,1,0, wr_bank 1,0,1.
//  i_start re-pulsed at cycles 5 and 16 -> trace identical to single start; no second run.
//  i_rst asserted at cycle 10 -> outputs 0 same cycle; no wr_en after; new start runs clean.
//  RD_LAT=0,BFLY_LAT=1 -> stage=5 cycles, o_done at cycle 16; wr lags rd by exactly 1.
//  Full system with Butterfly_Unit, input x=[1,0,...,0] -> all 8 outputs 1.0+0j in bank 1.

Source files
------------

// File: rtl/fft8_bfly_scheduler_if.sv
// Handshake and buffer-control bundle between the FFT8 butterfly scheduler and its
// control, ping-pong buffer, twiddle ROM and butterfly neighbours.
interface fft8_bfly_scheduler_if;
  logic       i_start;
  logic       o_busy;
  logic       o_done;
  logic       o_rd_valid;
  logic       o_rd_bank;
  logic [2:0] o_rd_addr0;
  logic [2:0] o_rd_addr1;
  logic [1:0] o_tw_idx;
  logic [1:0] o_stage;
  logic       o_wr_en;
  logic       o_wr_bank;
  logic [2:0] o_wr_addr0;
  logic [2:0] o_wr_addr1;

  modport master (
    input  i_start,
    output o_busy, o_done,
    output o_rd_valid, o_rd_bank, o_rd_addr0, o_rd_addr1, o_tw_idx, o_stage,
    output o_wr_en, o_wr_bank, o_wr_addr0, o_wr_addr1
  );

  modport slave (
    output i_start,
    input  o_busy, o_done,
    input  o_rd_valid, o_rd_bank, o_rd_addr0, o_rd_addr1, o_tw_idx, o_stage,
    input  o_wr_en, o_wr_bank, o_wr_addr0, o_wr_addr1
  );
endinterface

// File: rtl/fft8_bfly_scheduler.sv
// Sequences one shared radix-2 butterfly through the three DIT stages of an 8-point FFT,
// issuing reads from one ping-pong bank and writing results back PIPE cycles later.
module fft8_bfly_scheduler #(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned BFLY_LAT = 2
) (
  input logic                   i_clk,
  input logic                   i_rst,
  fft8_bfly_scheduler_if.master bus
);

  localparam int unsigned PIPE = RD_LAT + BFLY_LAT;
  localparam int unsigned DW   = (PIPE > 1) ? $clog2(PIPE) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic       valid;
    logic       bank;
    logic [2:0] addr0;
    logic [2:0] addr1;
  } wb_t;

  logic [1:0]    state_q, state_d;
  logic [1:0]    stage_q, stage_d;
  logic [1:0]    k_q, k_d;
  logic [DW-1:0] drain_q, drain_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_bank_q, rd_bank_d;
  logic [2:0]    rd_addr0_q, rd_addr0_d;
  logic [2:0]    rd_addr1_q, rd_addr1_d;
  logic [1:0]    tw_idx_q, tw_idx_d;
  logic [1:0]    stage_o_q, stage_o_d;

  wb_t           sr_q [PIPE];
  wb_t           sr_d [PIPE];

  logic [2:0]    bf_addr0_c;
  logic [2:0]    bf_addr1_c;
  logic [1:0]    bf_tw_c;

  // Butterfly k of stage s: span = 2^s, pair (addr0, addr0+span), twiddle pos << (2-s).
  always_comb begin
    bf_addr0_c = 3'd0;
    bf_addr1_c = 3'd0;
    bf_tw_c    = 2'd0;
    case (stage_q)
      2'd0: begin
        bf_addr0_c = {k_q, 1'b0};
        bf_addr1_c = {k_q, 1'b1};
        bf_tw_c    = 2'd0;
      end
      2'd1: begin
        bf_addr0_c = {k_q[1], 1'b0, k_q[0]};
        bf_addr1_c = {k_q[1], 1'b1, k_q[0]};
        bf_tw_c    = {k_q[0], 1'b0};
      end
      default: begin
        bf_addr0_c = {1'b0, k_q};
        bf_addr1_c = {1'b1, k_q};
        bf_tw_c    = k_q;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      stage_q <= 2'd0;
      k_q     <= 2'd0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      drain_q <= drain_d;
    end
  end

  // Next state plus the issue-side outputs, registered one cycle behind the state.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    k_d        = k_q;
    drain_d    = drain_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_bank_d  = 1'b0;
    rd_addr0_d = 3'd0;
    rd_addr1_d = 3'd0;
    tw_idx_d   = 2'd0;
    stage_o_d  = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d = S_ISSUE;
          stage_d = 2'd0;
          k_d     = 2'd0;
          drain_d = '0;
        end
      end

      S_ISSUE: begin
        busy_d     = 1'b1;
        stage_o_d  = stage_q;
        rd_valid_d = 1'b1;
        rd_bank_d  = stage_q[0];
        rd_addr0_d = bf_addr0_c;
        rd_addr1_d = bf_addr1_c;
        tw_idx_d   = bf_tw_c;
        k_d        = 2'(k_q + 2'd1);
        if (k_q == 2'd3) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end

      // Wait until the stage's last write-back lands before the next stage reads.
      S_DRAIN: begin
        busy_d    = 1'b1;
        stage_o_d = stage_q;
        if (drain_q == DW'(PIPE - 1)) begin
          drain_d = '0;
          k_d     = 2'd0;
          if (stage_q == 2'd2) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            stage_d = 2'(stage_q + 2'd1);
          end
        end else begin
          drain_d = DW'(drain_q + 1'b1);
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        stage_d = 2'd0;
      end

      default: begin
        state_d = S_IDLE;
        stage_d = 2'd0;
        k_d     = 2'd0;
        drain_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_addr0_q <= 3'd0;
      rd_addr1_q <= 3'd0;
      tw_idx_q   <= 2'd0;
      stage_o_q  <= 2'd0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_bank_q  <= rd_bank_d;
      rd_addr0_q <= rd_addr0_d;
      rd_addr1_q <= rd_addr1_d;
      tw_idx_q   <= tw_idx_d;
      stage_o_q  <= stage_o_d;
    end
  end

  // Write-back delay line fed by the registered issue; last tap lands PIPE cycles later.
  always_comb begin
    for (int i = 0; i < int'(PIPE); i++) begin
      sr_d[i] = '0;
    end
    sr_d[0].valid = rd_valid_q;
    sr_d[0].bank  = rd_valid_q & ~rd_bank_q;
    sr_d[0].addr0 = rd_addr0_q;
    sr_d[0].addr1 = rd_addr1_q;
    for (int i = 1; i < int'(PIPE); i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(PIPE); i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(PIPE); i++) begin
        sr_q[i] <= sr_d[i];
      end
    end
  end

  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_rd_bank  = rd_bank_q;
  assign bus.o_rd_addr0 = rd_addr0_q;
  assign bus.o_rd_addr1 = rd_addr1_q;
  assign bus.o_tw_idx   = tw_idx_q;
  assign bus.o_stage    = stage_o_q;
  assign bus.o_wr_en    = sr_q[PIPE-1].valid;
  assign bus.o_wr_bank  = sr_q[PIPE-1].bank;
  assign bus.o_wr_addr0 = sr_q[PIPE-1].addr0;
  assign bus.o_wr_addr1 = sr_q[PIPE-1].addr1;

endmodule

// File: tb/tb_fft8_bfly_scheduler.sv
// Directed bench for fft8_bfly_scheduler: default pipeline (PIPE=3) and a short one (PIPE=1).
module tb_fft8_bfly_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fft8_bfly_scheduler_if bus();
  fft8_bfly_scheduler_if bus_s();

  fft8_bfly_scheduler u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  fft8_bfly_scheduler #(.RD_LAT(0), .BFLY_LAT(1)) u_short (
    .i_clk (clk),
    .i_rst (rst_s),
    .bus   (bus_s.master)
  );

  // Hand-derived butterfly table, index = 4*stage + k.
  logic [2:0] e_a0 [12] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
  logic [2:0] e_a1 [12] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [1:0] e_tw [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};

  function automatic logic [21:0] all_o(input bit sel);
    if (sel)
      return {bus_s.o_busy, bus_s.o_done, bus_s.o_rd_valid, bus_s.o_rd_bank, bus_s.o_rd_addr0,
              bus_s.o_rd_addr1, bus_s.o_tw_idx, bus_s.o_stage, bus_s.o_wr_en, bus_s.o_wr_bank,
              bus_s.o_wr_addr0, bus_s.o_wr_addr1};
    return {bus.o_busy, bus.o_done, bus.o_rd_valid, bus.o_rd_bank, bus.o_rd_addr0,
            bus.o_rd_addr1, bus.o_tw_idx, bus.o_stage, bus.o_wr_en, bus.o_wr_bank,
            bus.o_wr_addr0, bus.o_wr_addr1};
  endfunction

  task automatic drive_start(input bit sel, input logic v);
    if (sel) bus_s.i_start = v;
    else     bus.i_start   = v;
  endtask

  task automatic test_reset();
    logic [21:0] o;
    bus.i_start   = 1'b0;
    bus_s.i_start = 1'b0;
    #12;
    o = all_o(1'b0);
    checks++;
    if (o !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", o, 22'd0);
    end
    o = all_o(1'b1);
    checks++;
    if (o !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs_short got %h exp %h", o, 22'd0);
    end
    @(negedge clk);
    rst   = 1'b0;
    rst_s = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      o = all_o(1'b0);
      checks++;
      if (o !== 22'd0) begin
        errors++;
        $display("FAIL idle_outputs cyc=%0d got %h exp %h", n, o, 22'd0);
      end
    end
  endtask

  // Full-run trace: start sampled at edge 0, cycle n sampled #1 after edge n.
  task automatic test_trace(input bit sel, input bit repulse, input int L, input int P);
    logic [9:0]  rd_o, rd_e;
    logic [7:0]  wr_o, wr_e;
    logic [3:0]  ct_o, ct_e;
    logic [21:0] o;
    int idx;
    drive_start(sel, 1'b1);
    @(posedge clk);
    #1;
    drive_start(sel, 1'b0);
    for (int n = 1; n <= 3*L + 8; n++) begin
      @(posedge clk);
      #1;
      rd_e = '0;
      wr_e = '0;
      for (int s = 0; s < 3; s++) begin
        idx = n - 1 - L*s;
        if (idx >= 0 && idx < 4)
          rd_e = {1'b1, s[0], e_a0[4*s+idx], e_a1[4*s+idx], e_tw[4*s+idx]};
        idx = n - 1 - P - L*s;
        if (idx >= 0 && idx < 4)
          wr_e = {1'b1, ~s[0], e_a0[4*s+idx], e_a1[4*s+idx]};
      end
      ct_e = {n <= 3*L, n == 3*L + 1, (n <= 3*L) ? 2'((n-1)/L) : 2'd0};
      o    = all_o(sel);
      rd_o = {o[19:18], o[17:15], o[14:12], o[11:10]};
      wr_o = o[7:0];
      ct_o = {o[21:20], o[9:8]};
      checks++;
      if (rd_o !== rd_e) begin
        errors++;
        $display("FAIL rd_trace sel=%0d cyc=%0d got %h exp %h", sel, n, rd_o, rd_e);
      end
      checks++;
      if (wr_o !== wr_e) begin
        errors++;
        $display("FAIL wr_trace sel=%0d cyc=%0d got %h exp %h", sel, n, wr_o, wr_e);
      end
      checks++;
      if (ct_o !== ct_e) begin
        errors++;
        $display("FAIL ctl_trace sel=%0d cyc=%0d got %h exp %h", sel, n, ct_o, ct_e);
      end
      drive_start(sel, repulse && (n == 5 || n == 16));
    end
    drive_start(sel, 1'b0);
  endtask

  task automatic test_mid_reset();
    logic [21:0] o;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus.o_rd_valid !== 1'b1 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_active got rv=%b busy=%b exp 1 1", bus.o_rd_valid, bus.o_busy);
    end
    #1;
    rst = 1'b1;
    #1;
    o = all_o(1'b0);
    checks++;
    if (o !== 22'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %h exp %h", o, 22'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      o = all_o(1'b0);
      checks++;
      if (o !== 22'd0) begin
        errors++;
        $display("FAIL post_reset_quiet cyc=%0d got %h exp %h", n, o, 22'd0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_trace(1'b0, 1'b0, 7, 3);
    test_trace(1'b0, 1'b1, 7, 3);
    test_mid_reset();
    test_trace(1'b0, 1'b0, 7, 3);
    test_trace(1'b1, 1'b0, 5, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
